i2c_target: RTL and testbench

Open-drain I2C target (responder) that answers the SoC's `i2c` master on the `io_scl`/`io_sda` pins. It holds a 16 x 8-bit register bank that the remote master writes and reads using a pointer protocol. The SoC side sees write events and has a local read port. It is used both as an on-board peripheral and as the loopback responder in SoC benches.

---
 rtl/i2c_target.sv | 168 ++++++++++++++++
 tb/tb_i2c_target.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C target with a 16 x 8-bit register bank addressed through a write pointer.
// The remote master is the only writer; the SoC gets write events and a combinational read port.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       wr_strobe_o,
    output logic [3:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    input  logic [3:0] loc_addr_i,
    output logic [7:0] loc_data_o,
    output logic       busy_o
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_BYTE  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_BYTE  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    // [0],[1] synchronize, [2] holds the previous synchronized sample
    logic [2:0] scl_pipe, sda_pipe;
    logic       scl_s, scl_p, sda_s, sda_p;
    logic       rise, fall, start_ev, stop_ev;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [3:0] ptr;
    logic       rw, first;
    logic [7:0] regs [16];

    assign scl_s    = scl_pipe[1];
    assign scl_p    = scl_pipe[2];
    assign sda_s    = sda_pipe[1];
    assign sda_p    = sda_pipe[2];
    assign rise     = scl_s & ~scl_p;
    assign fall     = ~scl_s & scl_p;
    assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;

    assign loc_data_o = regs[loc_addr_i];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_pipe    <= '1;
            sda_pipe    <= '1;
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            first       <= 1'b0;
            sda_oe_o    <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            busy_o      <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            scl_pipe    <= {scl_pipe[1:0], scl_i};
            sda_pipe    <= {sda_pipe[1:0], sda_i};
            wr_strobe_o <= 1'b0;
            // bus conditions win over anything the byte engine is doing
            if (start_ev) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (stop_ev) begin
                state    <= IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shreg[7:1] == DEV_ADDR) begin
                                sda_oe_o <= 1'b1;
                                busy_o   <= 1'b1;
                                rw       <= shreg[0];
                                state    <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (fall) begin
                            if (!rw) begin
                                sda_oe_o <= 1'b0;
                                first    <= 1'b1;
                                state    <= WR_BYTE;
                            end else begin
                                shreg    <= regs[ptr];
                                sda_oe_o <= ~regs[ptr][7];
                                state    <= RD_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (fall && bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            sda_oe_o <= 1'b1;
                            state    <= WR_ACK;
                            // first byte after the address is the pointer, not data
                            if (first) begin
                                ptr   <= shreg[3:0];
                                first <= 1'b0;
                            end else begin
                                regs[ptr]   <= shreg;
                                wr_strobe_o <= 1'b1;
                                wr_addr_o   <= ptr;
                                wr_data_o   <= shreg;
                                ptr         <= ptr + 4'd1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (fall) begin
                            sda_oe_o <= 1'b0;
                            state    <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        if (fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt  <= '0;
                                sda_oe_o <= 1'b0;
                                ptr      <= ptr + 4'd1;
                                state    <= RD_ACK;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b0};
                                sda_oe_o <= ~shreg[6];
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (rise && sda_s) begin
                            state <= IGNORE;
                        end else if (fall) begin
                            shreg    <= regs[ptr];
                            sda_oe_o <= ~regs[ptr][7];
                            bit_cnt  <= '0;
                            state    <= RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Bench for i2c_target: a bit-banged master drives the bus, and a scoreboard
// monitor compares write strobes, read bytes and queued point checks.
module tb_i2c_target;
    localparam int Q = 50;  // quarter SCL period: 5 clk

    logic       clk = 1'b0, rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_oe, wr_strobe, busy, sda_bus;
    logic [3:0] wr_addr, loc_addr = 4'd0;
    logic [7:0] wr_data, loc_data;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe_o(sda_oe), .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .loc_addr_i(loc_addr), .loc_data_o(loc_data),
        .busy_o(busy)
    );

    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { int act; int exp; } chk_t;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$], act_rd[$];
    chk_t       chk_q[$];
    string      chk_nm[$];
    int         n_cmp = 0, n_bad = 0;
    int         oe_cnt = 0, busy_cnt = 0, oe_hi_viol = 0;
    logic       oe_q = 1'b0;

    function automatic void cmp(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // scoreboard monitor: the only place comparisons happen
    always @(negedge clk) begin : mon
        wr_t        e;
        chk_t       c;
        logic [7:0] a;
        if (rst && wr_strobe) begin
            if (exp_wr.size() == 0) cmp("wr_strobe_unexpected", 1, 0);
            else begin
                e = exp_wr.pop_front();
                cmp("wr_strobe", int'({wr_addr, wr_data}), int'({e.a, e.d}));
            end
        end
        while (act_rd.size() > 0) begin
            a = act_rd.pop_front();
            if (exp_rd.size() == 0) cmp("rd_byte_unexpected", 1, 0);
            else cmp("rd_byte", int'(a), int'(exp_rd.pop_front()));
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(chk_nm.pop_front(), c.act, c.exp);
        end
    end

    always @(posedge clk) begin
        oe_q     <= sda_oe;
        oe_cnt   <= oe_cnt + int'(sda_oe);
        busy_cnt <= busy_cnt + int'(busy);
        if (scl_m && sda_oe && !oe_q) oe_hi_viol <= oe_hi_viol + 1;
    end

    task automatic chk(string nm, int act, int exp);
        chk_t c;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
        chk_nm.push_back(nm);
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        s = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic start_c();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #(2*Q);
        sda_m = 1'b0; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic stop_c();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #(2*Q);
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic wba(input logic [7:0] b);
        logic a;
        wbyte(b, a);
        chk($sformatf("ack_%02h", b), int'(a), 1);
    endtask

    task automatic rbyte(input logic ack);
        logic       s;
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, s);
            d = {d[6:0], s};
        end
        bit_x(~ack, s);
        act_rd.push_back(d);
    endtask

    task automatic wr_exp(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic loc_chk(input logic [3:0] a, input logic [7:0] d);
        loc_addr = a; #1;
        chk($sformatf("loc_%0d", a), int'(loc_data), int'(d));
    endtask

    initial begin : main
        logic a;
        int   oe0, bz0;
        repeat (3) @(posedge clk); #2;
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_strobe", int'(wr_strobe), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_loc0", int'(loc_data), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk); #2;

        // write with auto-increment
        start_c(); wba(8'hA0);
        chk("busy_after_match", int'(busy), 1);
        wba(8'h03);
        wr_exp(4'd3, 8'h11); wr_exp(4'd4, 8'h22);
        wba(8'h11); wba(8'h22); stop_c();
        chk("busy_after_stop", int'(busy), 0);
        loc_chk(4'd3, 8'h11); loc_chk(4'd4, 8'h22);

        // seed regs[5] so the pointer after the read is observable
        start_c(); wba(8'hA0); wba(8'h05);
        wr_exp(4'd5, 8'h55); wba(8'h55); stop_c();

        // read with repeated start, ACK then NACK
        start_c(); wba(8'hA0); wba(8'h03);
        start_c(); wba(8'hA1);
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
        rbyte(1'b1); rbyte(1'b0);
        chk("sda_released_after_nack", int'(sda_oe), 0);
        stop_c();
        // current-address read shows ptr = 5
        start_c(); wba(8'hA1);
        exp_rd.push_back(8'h55); rbyte(1'b0); stop_c();

        // address mismatch
        oe0 = oe_cnt; bz0 = busy_cnt;
        start_c();
        wbyte(8'hA2, a); chk("mismatch_addr_nack", int'(a), 0);
        wbyte(8'h01, a); chk("mismatch_d0_nack", int'(a), 0);
        wbyte(8'h5A, a); chk("mismatch_d1_nack", int'(a), 0);
        wbyte(8'h00, a); chk("mismatch_d2_nack", int'(a), 0);
        stop_c();
        chk("mismatch_sda_oe_cycles", oe_cnt - oe0, 0);
        chk("mismatch_busy_cycles", busy_cnt - bz0, 0);

        // pointer wrap
        start_c(); wba(8'hA0); wba(8'h0F);
        wr_exp(4'd15, 8'hAA); wr_exp(4'd0, 8'hBB); wr_exp(4'd1, 8'hCC);
        wba(8'hAA); wba(8'hBB); wba(8'hCC); stop_c();
        loc_chk(4'd15, 8'hAA); loc_chk(4'd0, 8'hBB); loc_chk(4'd1, 8'hCC);
        start_c(); wba(8'hA1);
        exp_rd.push_back(8'h00); rbyte(1'b0); stop_c();

        // abort mid-byte: 4 data bits then STOP, no strobe
        start_c(); wba(8'hA0); wba(8'h07);
        for (int i = 0; i < 4; i++) bit_x(1'b1, a);
        stop_c();
        chk("abort_busy", int'(busy), 0);
        start_c(); wba(8'hA0); wba(8'h07);
        wr_exp(4'd7, 8'h3C); wba(8'h3C); stop_c();
        loc_chk(4'd7, 8'h3C);

        // reset while target drives the 0 MSB of regs[3] = 0x11
        start_c(); wba(8'hA0); wba(8'h03);
        start_c(); wba(8'hA1);
        chk("target_drives_zero", int'(sda_oe), 1);
        #3 rst = 1'b0;
        #1 chk("oe_async_drop", int'(sda_oe), 0);
        repeat (3) @(posedge clk); #2;
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(posedge clk); #2;
        rst = 1'b1;
        repeat (5) @(posedge clk); #2;
        chk("post_rst_busy", int'(busy), 0);
        loc_chk(4'd3, 8'h00); loc_chk(4'd7, 8'h00); loc_chk(4'd15, 8'h00);
        start_c(); wba(8'hA1);
        exp_rd.push_back(8'h00); rbyte(1'b0); stop_c();

        chk("oe_rise_while_scl_high", oe_hi_viol, 0);
        repeat (5) @(negedge clk);
        chk("wr_q_left", exp_wr.size(), 0);
        chk("rd_q_left", exp_rd.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
